// File: rtl/control_ciclo.sv
// control_ciclo: phase sequencer for the ciclo_master cycle counter.
// Holds a small duration table and steps ciclo_master through it.
module control_ciclo #(
    parameter int N_FASES = 4,
    parameter int ANCHO   = 6,
    parameter int TIEMPO  = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      repetir,
    input  logic [1:0]                num_fases,
    input  logic                      cfg_we,
    input  logic [1:0]                cfg_addr,
    input  logic [ANCHO-1:0]          cfg_data,
    input  logic [ANCHO-1:0]          ciclo,
    input  logic [$clog2(TIEMPO)-1:0] cuenta,
    output logic                      EN_ciclo,
    output logic [ANCHO-1:0]          duracion,
    output logic [1:0]                fase,
    output logic                      busy,
    output logic                      tick_fase,
    output logic                      done,
    output logic                      error
);

    localparam int CW = $clog2(TIEMPO);
    localparam logic [CW-1:0] CUENTA_FIN = CW'(TIEMPO - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CORRER = 2'd1,
        FIN    = 2'd2
    } estado_t;

    estado_t          estado_q;
    logic [ANCHO-1:0] tabla_q [N_FASES];

    logic             en_q;
    logic [ANCHO-1:0] dur_q;
    logic [1:0]       fase_q;
    logic [1:0]       nfl_q;
    logic             busy_q;
    logic             tick_q;
    logic             done_q;
    logic             error_q;

    logic             wr_ok;
    logic             tabla_ok;
    logic             fin_fase;
    logic             ultima;
    logic             pide_start;
    logic [1:0]       fase_d;
    logic [ANCHO-1:0] dur_d;
    logic [ANCHO-1:0] dur_fin;

    // Table writes are only accepted while the sequencer is idle.
    assign wr_ok = cfg_we && (estado_q == IDLE);

    // A start is considered only when no abort arrives alongside it.
    assign pide_start = start && !stop;

    // Last ciclo value of the active phase; duration is never zero here.
    assign dur_fin = dur_q - ANCHO'(1);

    // End of phase coincides with ciclo_master wrapping ciclo back to 0.
    assign fin_fase = en_q
                   && (cuenta == CUENTA_FIN)
                   && (ciclo == dur_fin);

    assign ultima = (fase_q == nfl_q);
    assign fase_d = fase_q + 2'd1;
    assign dur_d  = tabla_q[fase_d];

    // Every entry from 0 up to the requested last phase must be nonzero.
    always_comb begin
        tabla_ok = 1'b1;
        for (int i = 0; i < N_FASES; i++) begin
            if ((i <= int'(num_fases)) && (tabla_q[i] == '0)) begin
                tabla_ok = 1'b0;
            end
        end
    end

    // Duration table; cleared by reset, written only from IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_FASES; i++) begin
                tabla_q[i] <= '0;
            end
        end else if (wr_ok) begin
            tabla_q[cfg_addr] <= cfg_data;
        end
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q <= IDLE;
            en_q     <= 1'b0;
            dur_q    <= '0;
            fase_q   <= 2'd0;
            nfl_q    <= 2'd0;
            busy_q   <= 1'b0;
            tick_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            done_q <= 1'b0;
            if (stop && (estado_q != IDLE)) begin
                estado_q <= IDLE;
                en_q     <= 1'b0;
                busy_q   <= 1'b0;
                fase_q   <= 2'd0;
            end else begin
                case (estado_q)
                    IDLE: begin
                        if (pide_start) begin
                            if (tabla_ok) begin
                                estado_q <= CORRER;
                                nfl_q    <= num_fases;
                                dur_q    <= tabla_q[0];
                                fase_q   <= 2'd0;
                                en_q     <= 1'b1;
                                busy_q   <= 1'b1;
                                error_q  <= 1'b0;
                            end else begin
                                error_q <= 1'b1;
                            end
                        end else if (wr_ok) begin
                            error_q <= 1'b0;
                        end
                    end
                    CORRER: begin
                        if (fin_fase) begin
                            tick_q <= 1'b1;
                            if (!ultima) begin
                                fase_q <= fase_d;
                                dur_q  <= dur_d;
                            end else if (repetir) begin
                                fase_q <= 2'd0;
                                dur_q  <= tabla_q[0];
                            end else begin
                                en_q     <= 1'b0;
                                estado_q <= FIN;
                            end
                        end
                    end
                    FIN: begin
                        // First FIN cycle raises done; the next returns to IDLE.
                        if (!done_q) begin
                            done_q <= 1'b1;
                            busy_q <= 1'b0;
                        end else begin
                            estado_q <= IDLE;
                        end
                    end
                    default: begin
                        estado_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign EN_ciclo  = en_q;
    assign duracion  = dur_q;
    assign fase      = fase_q;
    assign busy      = busy_q;
    assign tick_fase = tick_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule

// File: tb/tb_control_ciclo.sv
// tb_control_ciclo: closed-loop bench with a ciclo_master model.
// Expected phase events are queued by stimulus and checked by a monitor.
module tb_control_ciclo;

    localparam int T = 32;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       stop;
    logic       repetir;
    logic [1:0] num_fases;
    logic       cfg_we;
    logic [1:0] cfg_addr;
    logic [5:0] cfg_data;
    logic [5:0] ciclo;
    logic [4:0] cuenta;
    logic       EN_ciclo;
    logic [5:0] duracion;
    logic [1:0] fase;
    logic       busy;
    logic       tick_fase;
    logic       done;
    logic       error;

    typedef struct {
        logic       fin;
        logic [1:0] f;
        logic [5:0] d;
        logic       en;
        logic       b;
    } ev_t;

    ev_t q[$];
    int  checks = 0;
    int  errors = 0;

    control_ciclo #(.N_FASES(4), .ANCHO(6), .TIEMPO(T)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .repetir   (repetir),
        .num_fases (num_fases),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .ciclo     (ciclo),
        .cuenta    (cuenta),
        .EN_ciclo  (EN_ciclo),
        .duracion  (duracion),
        .fase      (fase),
        .busy      (busy),
        .tick_fase (tick_fase),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    // ciclo_master model: inner count 0..T-1, ciclo wraps at duracion-1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ciclo  <= '0;
            cuenta <= '0;
        end else if (!EN_ciclo) begin
            ciclo  <= '0;
            cuenta <= '0;
        end else if (cuenta == 5'(T - 1)) begin
            cuenta <= '0;
            ciclo  <= (ciclo == duracion - 6'd1) ? 6'd0 : ciclo + 6'd1;
        end else begin
            cuenta <= cuenta + 5'd1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic fin, input logic [1:0] f,
                        input logic [5:0] d, input logic en, input logic b);
        ev_t e;
        e.fin = fin;
        e.f   = f;
        e.d   = d;
        e.en  = en;
        e.b   = b;
        q.push_back(e);
    endtask

    task automatic wait_empty(input int budget);
        int n;
        n = 0;
        while (q.size() != 0 && n < budget) begin
            @(posedge clk);
            #2;
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL wait_events: %0d events pending after %0d cycles, expected 0",
                     q.size(), budget);
            q.delete();
        end
    endtask

    task automatic cfg(input logic [1:0] a, input logic [5:0] d);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic pulse_start(input logic [1:0] nf);
        num_fases = nf;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
    endtask

    task automatic monitor();
        ev_t e;
        forever begin
            @(negedge clk);
            if (!reset && (tick_fase || done)) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: tick=%0b done=%0b fase=%0d, expected no event",
                             tick_fase, done, fase);
                end else begin
                    e = q.pop_front();
                    if (done !== e.fin || tick_fase === e.fin || fase !== e.f ||
                        duracion !== e.d || EN_ciclo !== e.en || busy !== e.b) begin
                        errors++;
                        $display("FAIL phase_event: got done=%0b tick=%0b fase=%0d dur=%0d en=%0b busy=%0b expected done=%0b fase=%0d dur=%0d en=%0b busy=%0b",
                                 done, tick_fase, fase, duracion, EN_ciclo, busy,
                                 e.fin, e.f, e.d, e.en, e.b);
                    end
                end
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        reset     = 1'b1;
        start     = 1'b0;
        stop      = 1'b0;
        repetir   = 1'b0;
        num_fases = 2'd0;
        cfg_we    = 1'b0;
        cfg_addr  = 2'd0;
        cfg_data  = 6'd0;
        fork
            monitor();
        join_none
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;

        chk("rst_en", EN_ciclo, 0);
        chk("rst_dur", duracion, 0);
        chk("rst_fase", fase, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tick", tick_fase, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);

        // single pass {2,3}
        cfg(2'd0, 6'd2);
        cfg(2'd1, 6'd3);
        push(0, 2'd1, 6'd3, 1, 1);
        push(0, 2'd1, 6'd3, 0, 1);
        push(1, 2'd1, 6'd3, 0, 0);
        repetir = 1'b0;
        pulse_start(2'd1);
        chk("sp_en", EN_ciclo, 1);
        chk("sp_busy", busy, 1);
        chk("sp_fase", fase, 0);
        chk("sp_dur", duracion, 2);
        wait_empty(400);
        chk("sp_done_pulse", done, 0);
        chk("sp_busy_end", busy, 0);
        chk("sp_en_end", EN_ciclo, 0);

        // repeating {1,1,1,1}
        for (int i = 0; i < 4; i++) cfg(2'(i), 6'd1);
        repetir = 1'b1;
        for (int i = 1; i <= 10; i++) push(0, 2'(i % 4), 6'd1, 1, 1);
        pulse_start(2'd3);
        wait_empty(700);
        chk("rep_busy", busy, 1);
        repetir = 1'b0;
        push(0, 2'd3, 6'd1, 1, 1);
        push(0, 2'd3, 6'd1, 0, 1);
        push(1, 2'd3, 6'd1, 0, 0);
        wait_empty(200);
        chk("rep_busy_end", busy, 0);

        // rejected start
        cfg(2'd0, 6'd5);
        cfg(2'd1, 6'd0);
        pulse_start(2'd1);
        chk("rej_error", error, 1);
        chk("rej_busy", busy, 0);
        chk("rej_en", EN_ciclo, 0);
        cfg(2'd1, 6'd4);
        chk("rej_error_clr", error, 0);
        pulse_start(2'd1);
        chk("rej_ok_busy", busy, 1);
        chk("rej_ok_dur", duracion, 5);
        pulse_stop();
        chk("rej_stop_en", EN_ciclo, 0);

        // stop mid phase 1 of {3,3}
        cfg(2'd0, 6'd3);
        cfg(2'd1, 6'd3);
        push(0, 2'd1, 6'd3, 1, 1);
        pulse_start(2'd1);
        wait_empty(300);
        repeat (10) @(posedge clk);
        #2;
        pulse_stop();
        chk("stop_en", EN_ciclo, 0);
        chk("stop_busy", busy, 0);
        chk("stop_fase", fase, 0);
        repeat (20) @(posedge clk);
        #2;

        // stop coincident with phase end
        push(0, 2'd1, 6'd3, 1, 1);
        pulse_start(2'd1);
        wait_empty(300);
        n = 0;
        while (!(EN_ciclo && cuenta == 5'(T - 1) && ciclo == duracion - 6'd1)
               && n < 400) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("fin_found", n < 400, 1);
        pulse_stop();
        chk("stopfin_tick", tick_fase, 0);
        chk("stopfin_en", EN_ciclo, 0);
        chk("stopfin_fase", fase, 0);
        repeat (5) @(posedge clk);
        #2;

        // writes and start while busy
        cfg(2'd0, 6'd2);
        cfg(2'd1, 6'd3);
        push(0, 2'd1, 6'd3, 1, 1);
        push(0, 2'd1, 6'd3, 0, 1);
        push(1, 2'd1, 6'd3, 0, 0);
        pulse_start(2'd1);
        repeat (10) @(posedge clk);
        #2;
        cfg(2'd0, 6'd7);
        pulse_start(2'd3);
        chk("busy_fase", fase, 0);
        chk("busy_dur", duracion, 2);
        wait_empty(400);
        pulse_start(2'd0);
        chk("busy_tab0", duracion, 2);
        pulse_stop();

        // async reset mid-run
        pulse_start(2'd1);
        repeat (5) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("arst_en", EN_ciclo, 0);
        chk("arst_busy", busy, 0);
        chk("arst_dur", duracion, 0);
        chk("arst_fase", fase, 0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        pulse_start(2'd0);
        chk("arst_tab_clr", error, 1);
        chk("arst_idle", busy, 0);
        repeat (3) @(posedge clk);
        #2;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
